mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Consumes the registered ALU result, the opcode, the store data (TARG value) and the destination register number.
- Performs the LW/SW data-memory transaction over a req/ack interface with variable latency and produces a write-back packet.
- Non-memory opcodes pass straight through to write-back.
- Upstream and downstream use valid/ready handshakes.

Parameters:
- TIMEOUT, 255: maximum cycles mem_req is held without mem_ack before a bus error is reported (range 1..255).
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream packet valid
- in_ready  output  1  stage can accept; high only in IDLE
- opcode  input  6  instruction opcode
- alu_result  input  32  ALU output; byte address for LW/SW
- store_data  input  32  TARG register value, written on SW
- dest_reg  input  5  write-back register number
- mem_req  output  1  data-memory request
- mem_we  output  1  1 = write (SW), 0 = read (LW)
- mem_addr  output  32  word-aligned byte address
- mem_wdata  output  32  store data
- mem_rdata  input  32  load data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse
- out_valid  output  1  write-back packet valid
- out_ready  input  1  downstream accepts packet
- wb_en  output  1  register write enable
- wb_reg  output  5  register to write
- wb_data  output  32  value to write
- misalign  output  1  LW/SW address[1:0] != 0
- bus_err  output  1  memory timeout

Behaviour:
- Reset (async, immediate): state = IDLE. All outputs 0 except in_ready = 1. Timeout counter = 0. Applies in any state; a request in flight is abandoned and mem_req drops without waiting for a clock edge.
- All outputs are registered. States are IDLE, REQ and RESP.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1, capture opcode, alu_result, store_data and dest_reg, then classify:
    - LW (100011) or SW (101011) with alu_result[1:0] == 0: go to REQ. mem_req = 1, mem_we = (SW), mem_addr = alu_result, mem_wdata = store_data, counter = 0.
    - LW/SW with alu_result[1:0] != 0: no memory access. Go to RESP with misalign = 1, wb_en = 0.
    - R-type (000000), ADDI (001000), ANDI (001100): go to RESP with wb_data = alu_result, wb_reg = dest_reg, wb_en = (dest_reg != 0).
    - Branch (000100, 000101), J (000010) and any other opcode: go to RESP with wb_en = 0 and wb_data = alu_result.
- REQ:
  - in_ready = 0. mem_req and the mem_* outputs are held stable until ack.
  - Edge with mem_ack = 1:
    - mem_req drops to 0; go to RESP.
    - LW: wb_data = mem_rdata, wb_en = (dest_reg != 0).
    - SW: wb_en = 0.
  - Edge with mem_ack = 0: counter increments. When counter reaches TIMEOUT-1 on that edge, drop mem_req and go to RESP with bus_err = 1, wb_en = 0.
  - mem_ack takes priority over timeout on the same edge.
- RESP:
  - out_valid = 1; the packet is held stable while out_ready = 0.
  - Edge with out_ready = 1: out_valid, wb_en, misalign and bus_err clear to 0; go to IDLE.
  - No new packet is accepted in the same edge; throughput is one packet per 2 cycles minimum.
- Latency:
  - Non-memory or misaligned packet: accepted at edge N, out_valid high after edge N.
  - Memory packet: mem_req high after edge N; out_valid high after the edge that samples mem_ack.
- A mem_ack seen in IDLE or RESP is ignored; it does not alter state or outputs.
- misalign and bus_err are mutually exclusive and only meaningful while out_valid = 1.

Test Plan:
- Pass-through: opcode 000000, alu_result 0x0000_0007, dest_reg 3, out_ready = 1 -> one cycle later out_valid = 1, wb_en = 1, wb_reg = 3, wb_data = 7; mem_req never asserts.
- LW: alu_result 0x0000_0010, dest_reg 5, mem_ack pulsed 3 cycles after mem_req rises with mem_rdata = 0xDEAD_BEEF -> mem_addr = 0x10 and mem_we = 0 held 3 cycles; then out_valid = 1, wb_data = 0xDEAD_BEEF, wb_en = 1.
- SW and register 0: SW to 0x20 with store_data 0x1234_5678, immediate ack -> mem_we = 1, mem_wdata = 0x1234_5678, wb_en = 0. Separately, LW with dest_reg 0 -> wb_en = 0.
- Misalign: LW with alu_result 0x0000_0013 -> mem_req stays 0; next cycle out_valid = 1, misalign = 1, wb_en = 0.
- Timeout and stray ack: TIMEOUT = 4, no mem_ack -> mem_req high exactly 4 cycles, then bus_err = 1, out_valid = 1. A stray mem_ack in IDLE afterwards -> no state change.
- Backpressure and reset: out_ready held 0 for 5 cycles -> packet stable and in_ready = 0 throughout. Separately, rst pulsed mid-REQ -> mem_req = 0 immediately, in_ready = 1, state IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline stage after the ALU. Performs LW/SW over a
// variable-latency req/ack data-memory port, detects misaligned accesses and
// memory timeouts, and hands a write-back packet downstream over valid/ready.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Last counter value before the timeout fires: mem_req stays up for
  // exactly TIMEOUT cycles when no ack arrives.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TO_W-1:0] to_cnt;

  logic is_ls;
  logic is_alu;
  logic aligned;
  logic timeout_hit;

  // Decode of the incoming packet and the timeout condition.
  always_comb begin
    is_ls       = (opcode == OP_LW) || (opcode == OP_SW);
    is_alu      = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_ANDI);
    aligned     = (alu_result[1:0] == 2'b00);
    timeout_hit = (to_cnt == TO_LAST);
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned,
    // which would infer a latch.
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (is_ls && aligned) ? REQ : RESP;
      REQ:  if (mem_ack || timeout_hit) state_nx = RESP;
      RESP: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs: handshake flags follow the next state, datapath
  // fields are captured on accept and updated on memory completion.
  // NOTE: every output flop is in the async reset; there is no memory array
  // here, so nothing is left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == RESP);
      mem_req   <= (state_nx == REQ);
      case (state)
        IDLE: begin
          if (in_valid) begin
            mem_we    <= (opcode == OP_SW);
            mem_addr  <= alu_result;
            mem_wdata <= store_data;
            wb_reg    <= dest_reg;
            wb_data   <= alu_result;
            wb_en     <= is_alu && (dest_reg != 5'd0);
            misalign  <= is_ls && !aligned;
            bus_err   <= 1'b0;
            to_cnt    <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            // Stores never write back; loads return the memory word.
            if (!mem_we) begin
              wb_data <= mem_rdata;
              wb_en   <= (wb_reg != 5'd0);
            end
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            wb_en    <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized transactions, each compared against a transaction-level model.
module tb_mem_access_stage;

  localparam int TO = 4;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_result(alu_result),
    .store_data(store_data), .dest_reg(dest_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one packet, derived from the stage's rules.
  typedef struct {
    bit          goes_to_mem;
    bit          wb_en;
    bit          check_data;
    logic [31:0] wb_data;
    bit          misalign;
    bit          bus_err;
  } expect_t;

  function automatic expect_t model(input logic [5:0] op, input logic [31:0] addr,
                                    input logic [4:0] dest, input int lat,
                                    input logic [31:0] rd);
    expect_t e;
    bit ls  = (op == LW) || (op == SW);
    bit alu = (op == 6'b000000) || (op == 6'b001000) || (op == 6'b001100);
    e = '{default: 0};
    e.wb_data = addr;
    if (ls && (addr % 4 != 0)) begin
      e.misalign = 1;
    end else if (ls) begin
      e.goes_to_mem = 1;
      if (lat > TO) e.bus_err = 1;
      else if (op == LW) begin
        e.wb_en      = (dest != 0);
        e.check_data = 1;
        e.wb_data    = rd;
      end
    end else begin
      e.wb_en      = alu && (dest != 0);
      e.check_data = 1;
    end
    return e;
  endfunction

  // One full packet: accept, optional memory phase with ack after `lat`
  // cycles (lat > TO means no ack), `bp` cycles of backpressure, release.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] dest,
                         input int lat, input logic [31:0] rd, input int bp);
    expect_t e;
    int n;
    e = model(op, addr, dest, lat, rd);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    in_valid = 1; opcode = op; alu_result = addr; store_data = sd; dest_reg = dest;
    @(posedge clk); #1;
    in_valid = 0; opcode = 6'($urandom); alu_result = $urandom;
    store_data = $urandom; dest_reg = 5'($urandom);
    if (e.goes_to_mem) begin
      check("req_up", mem_req, 1);
      check("req_we", mem_we, op == SW);
      check("req_addr", mem_addr, addr);
      check("req_wdata", mem_wdata, sd);
      check("req_in_ready", in_ready, 0);
      check("req_out_valid", out_valid, 0);
      n = (lat < TO) ? lat : TO;
      for (int k = 1; k <= n; k++) begin
        if (k == lat) begin mem_ack = 1; mem_rdata = rd; end
        @(posedge clk); #1;
        mem_ack = 0; mem_rdata = $urandom;
        if (k < n) begin
          check("req_held", mem_req, 1);
          check("req_addr_held", mem_addr, addr);
        end
      end
    end
    check("req_down", mem_req, 0);
    check("resp_valid", out_valid, 1);
    check("resp_wb_en", wb_en, e.wb_en);
    check("resp_misalign", misalign, e.misalign);
    check("resp_bus_err", bus_err, e.bus_err);
    if (e.check_data) check("resp_wb_data", wb_data, e.wb_data);
    if (e.wb_en) check("resp_wb_reg", wb_reg, dest);
    for (int k = 0; k < bp; k++) begin
      mem_ack = 1'($urandom);
      @(posedge clk); #1;
      mem_ack = 0;
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_wb_en", wb_en, e.wb_en);
      check("bp_flags", {misalign, bus_err}, {e.misalign, e.bus_err});
      if (e.check_data) check("bp_wb_data", wb_data, e.wb_data);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("rel_valid", out_valid, 0);
    check("rel_in_ready", in_ready, 1);
    check("rel_flags", {wb_en, misalign, bus_err}, 0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] addr;
    rst = 1; in_valid = 0; opcode = 0; alu_result = 0; store_data = 0;
    dest_reg = 0; mem_rdata = 0; mem_ack = 0; out_ready = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_outs", {out_valid, mem_req, mem_we, wb_en, misalign, bus_err}, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 0;
    @(posedge clk); #1;

    // Directed scenarios.
    run_txn(6'b000000, 32'h7,  32'h0,         5'd3, 0, 32'h0,         0);
    run_txn(LW,        32'h10, 32'h0,         5'd5, 3, 32'hDEAD_BEEF, 0);
    run_txn(SW,        32'h20, 32'h1234_5678, 5'd9, 1, 32'h0,         0);
    run_txn(LW,        32'h24, 32'h0,         5'd0, 2, 32'hCAFE_F00D, 0);
    run_txn(LW,        32'h13, 32'h0,         5'd7, 0, 32'h0,         0);
    run_txn(SW,        32'h42, 32'h5,         5'd7, 0, 32'h0,         0);
    run_txn(LW,        32'h30, 32'h0,         5'd4, TO + 1, 32'h0,    0);
    run_txn(LW,        32'h34, 32'h0,         5'd6, TO, 32'h0BAD_CAFE, 0);
    run_txn(6'b000100, 32'h44, 32'h0,         5'd8, 0, 32'h0,         0);
    run_txn(6'b001000, 32'h99, 32'h0,         5'd0, 0, 32'h0,         0);

    // Stray ack in IDLE must not disturb anything.
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 0;
    check("stray_in_ready", in_ready, 1);
    check("stray_outs", {out_valid, mem_req, wb_en, bus_err}, 0);

    // Backpressure for 5 cycles.
    run_txn(6'b001100, 32'h55, 32'h0, 5'd12, 0, 32'h0, 5);
    run_txn(LW,        32'h8,  32'h0, 5'd13, 2, 32'h0123_4567, 5);

    // Reset in the middle of a request takes effect without a clock edge.
    in_valid = 1; opcode = LW; alu_result = 32'h40; dest_reg = 5'd2;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    check("midreq_req", mem_req, 1);
    #2 rst = 1;
    #1;
    check("async_rst_req", mem_req, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("post_rst_idle", {in_ready, mem_req, out_valid}, 3'b100);

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    op = LW;
        2:       op = SW;
        3:       op = 6'b000000;
        default: op = 6'($urandom);
      endcase
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_txn(op, addr, $urandom, 5'($urandom), $urandom_range(1, TO + 2),
              $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
